// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the CPU (port 0) and a loader (port 1).
// Optional per-port grant counters are enabled with `define DMEM_ARB_STATS_EN.
module dmem_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       gnt0_cnt,
    output logic [15:0]       gnt1_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

    state_t              state_q, state_d;
    logic                last_gnt_q, last_gnt_d;
    logic                owner_q, owner_d;
    logic [1:0]          lat_cnt_q, lat_cnt_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                rsp0_valid_q, rsp0_valid_d;
    logic                rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0]   rsp0_rdata_q, rsp0_rdata_d;
    logic [DATA_W-1:0]   rsp1_rdata_q, rsp1_rdata_d;
    logic                gnt0_s, gnt1_s;

    // Arbitration: a lone requester wins; on contention the port that was not granted last wins.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if ((state_q == S_IDLE) && !reset) begin
            gnt0_s = req0_valid && (!req1_valid || last_gnt_q);
            gnt1_s = req1_valid && (!req0_valid || !last_gnt_q);
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign req0_ready = gnt0_s;
    assign req1_ready = gnt1_s;

    // Next-state and registered-output logic for the access sequencer.
    always_comb begin
        state_d      = state_q;
        last_gnt_d   = last_gnt_q;
        owner_d      = owner_q;
        lat_cnt_d    = lat_cnt_q;
        mem_en_d     = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (gnt1_s) begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = req1_we;
                    mem_addr_d  = req1_addr;
                    mem_wdata_d = req1_wdata;
                    owner_d     = 1'b1;
                    last_gnt_d  = 1'b1;
                    state_d     = S_ISSUE;
                end else if (gnt0_s) begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = req0_we;
                    mem_addr_d  = req0_addr;
                    mem_wdata_d = req0_wdata;
                    owner_d     = 1'b0;
                    last_gnt_d  = 1'b0;
                    state_d     = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (mem_we_q) begin
                    rsp0_valid_d = !owner_q;
                    rsp1_valid_d = owner_q;
                    state_d      = S_RESP;
                end else begin
                    lat_cnt_d = LAT_INIT;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                // Read data is sampled in the last latency cycle so it is visible during RESP.
                if (lat_cnt_q == 2'd0) begin
                    if (owner_q) begin
                        rsp1_rdata_d = mem_rdata;
                    end else begin
                        rsp0_rdata_d = mem_rdata;
                    end
                    rsp0_valid_d = !owner_q;
                    rsp1_valid_d = owner_q;
                    state_d      = S_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                    state_d   = S_WAIT;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_gnt_q   <= 1'b1;
            owner_q      <= 1'b0;
            lat_cnt_q    <= 2'd0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_wdata_q  <= {DATA_W{1'b0}};
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= {DATA_W{1'b0}};
            rsp1_rdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            last_gnt_q   <= last_gnt_d;
            owner_q      <= owner_d;
            lat_cnt_q    <= lat_cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] gnt0_cnt_q;
    logic [15:0] gnt1_cnt_q;

    // Saturating counters of accepted handshakes per port.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt0_cnt_q <= 16'd0;
            gnt1_cnt_q <= 16'd0;
        end else begin
            if (gnt0_s && (gnt0_cnt_q != 16'hFFFF)) begin
                gnt0_cnt_q <= gnt0_cnt_q + 16'd1;
            end
            if (gnt1_s && (gnt1_cnt_q != 16'hFFFF)) begin
                gnt1_cnt_q <= gnt1_cnt_q + 16'd1;
            end
        end
    end

    assign gnt0_cnt = gnt0_cnt_q;
    assign gnt1_cnt = gnt1_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) against a transaction-level model.
module tb_dmem_arbiter;

    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int NCYC = 6000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          v     [2][2];
    logic          we    [2][2];
    logic [AW-1:0] a     [2][2];
    logic [DW-1:0] wd    [2][2];
    logic          rdy   [2][2];
    logic          rv    [2][2];
    logic [DW-1:0] rd    [2][2];
    logic          mem_en    [2];
    logic          mem_we    [2];
    logic [AW-1:0] mem_addr  [2];
    logic [DW-1:0] mem_wdata [2];
    logic [DW-1:0] mem_rdata [2];
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]   gcnt  [2][2];
`endif

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp_v);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int addr);
        if (addr == 5) return 32'hDEAD_BEEF;
        return 32'(addr) * 32'h9E37_79B1 + 32'h0BAD_F00D;
    endfunction

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut_lat1 (
        .clk(clk), .reset(reset),
        .req0_valid(v[0][0]), .req0_we(we[0][0]), .req0_addr(a[0][0]), .req0_wdata(wd[0][0]),
        .req0_ready(rdy[0][0]), .rsp0_valid(rv[0][0]), .rsp0_rdata(rd[0][0]),
        .req1_valid(v[0][1]), .req1_we(we[0][1]), .req1_addr(a[0][1]), .req1_wdata(wd[0][1]),
        .req1_ready(rdy[0][1]), .rsp1_valid(rv[0][1]), .rsp1_rdata(rd[0][1]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
`ifdef DMEM_ARB_STATS_EN
        , .gnt0_cnt(gcnt[0][0]), .gnt1_cnt(gcnt[0][1])
`endif
    );

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u_dut_lat3 (
        .clk(clk), .reset(reset),
        .req0_valid(v[1][0]), .req0_we(we[1][0]), .req0_addr(a[1][0]), .req0_wdata(wd[1][0]),
        .req0_ready(rdy[1][0]), .rsp0_valid(rv[1][0]), .rsp0_rdata(rd[1][0]),
        .req1_valid(v[1][1]), .req1_we(we[1][1]), .req1_addr(a[1][1]), .req1_wdata(wd[1][1]),
        .req1_ready(rdy[1][1]), .rsp1_valid(rv[1][1]), .rsp1_rdata(rd[1][1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
`ifdef DMEM_ARB_STATS_EN
        , .gnt0_cnt(gcnt[1][0]), .gnt1_cnt(gcnt[1][1])
`endif
    );

    // Memory devices: instance 0 returns data 1 cycle after mem_en, instance 1 after 3 cycles; noise otherwise.
    bit            started = 1'b0;
    logic [DW-1:0] dev_mem [2][1024];
    logic [DW-1:0] pipe    [2][3];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!started) begin
                for (int i = 0; i < 1024; i++) dev_mem[k][i] <= init_word(i);
            end else if (mem_en[k] && mem_we[k]) begin
                dev_mem[k][mem_addr[k]] <= mem_wdata[k];
            end
            pipe[k][0] <= (mem_en[k] && !mem_we[k]) ? dev_mem[k][mem_addr[k]] : $urandom;
            pipe[k][1] <= pipe[k][0];
            pipe[k][2] <= pipe[k][1];
        end
    end

    always_comb begin
        mem_rdata[0] = pipe[0][0];
        mem_rdata[1] = pipe[1][2];
    end

    // Reference model: one outstanding access, response due a fixed number of cycles after the handshake.
    int            cyc = 0;
    bit            acc      [2][2];
    bit            m_busy   [2];
    bit            m_last   [2];
    bit            m_owner  [2];
    bit            m_we     [2];
    int            m_hs_cyc [2];
    int            m_rsp_cyc[2];
    logic [DW-1:0] m_rval   [2];
    logic          e_mwe    [2];
    logic [AW-1:0] e_maddr  [2];
    logic [DW-1:0] e_mwdata [2];
    logic [DW-1:0] e_rdata  [2][2];
    int            m_cnt    [2][2];
    logic [DW-1:0] ref_mem  [2][1024];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic          idle, er0, er1, e_en, erv;
            logic [DW-1:0] nrd;
            int            lat, pi;
            string         pfx;
            lat  = (k == 0) ? 1 : 3;
            pfx  = $sformatf("lat%0d", lat);
            idle = !m_busy[k] && !reset;
            er0  = idle && v[k][0] && (!v[k][1] || m_last[k]);
            er1  = idle && v[k][1] && (!v[k][0] || !m_last[k]);
            e_en = m_busy[k] && (cyc == m_hs_cyc[k] + 1);
            if (started) begin
                check_eq({pfx, " req0_ready"}, {31'd0, rdy[k][0]}, {31'd0, er0});
                check_eq({pfx, " req1_ready"}, {31'd0, rdy[k][1]}, {31'd0, er1});
                check_eq({pfx, " mem_en"}, {31'd0, mem_en[k]}, {31'd0, e_en});
                check_eq({pfx, " mem_we"}, {31'd0, mem_we[k]}, {31'd0, e_mwe[k]});
                check_eq({pfx, " mem_addr"}, {22'd0, mem_addr[k]}, {22'd0, e_maddr[k]});
                check_eq({pfx, " mem_wdata"}, mem_wdata[k], e_mwdata[k]);
`ifdef DMEM_ARB_STATS_EN
                check_eq({pfx, " gnt0_cnt"}, {16'd0, gcnt[k][0]}, 32'(m_cnt[k][0]));
                check_eq({pfx, " gnt1_cnt"}, {16'd0, gcnt[k][1]}, 32'(m_cnt[k][1]));
`endif
            end
            for (int p = 0; p < 2; p++) begin
                erv = m_busy[k] && (cyc == m_rsp_cyc[k]) && (m_owner[k] == (p == 1));
                nrd = (erv && !m_we[k]) ? m_rval[k] : e_rdata[k][p];
                if (started) begin
                    check_eq($sformatf("%s rsp%0d_valid", pfx, p), {31'd0, rv[k][p]}, {31'd0, erv});
                    check_eq($sformatf("%s rsp%0d_rdata", pfx, p), rd[k][p], nrd);
                end
                if (!started || reset) e_rdata[k][p] <= {DW{1'b0}};
                else                   e_rdata[k][p] <= nrd;
            end
            acc[k][0] <= er0;
            acc[k][1] <= er1;
            if (!started) begin
                for (int i = 0; i < 1024; i++) ref_mem[k][i] <= init_word(i);
            end
            if (!started || reset) begin
                m_busy[k]   <= 1'b0;
                m_last[k]   <= 1'b1;
                e_mwe[k]    <= 1'b0;
                e_maddr[k]  <= {AW{1'b0}};
                e_mwdata[k] <= {DW{1'b0}};
                m_cnt[k][0] <= 0;
                m_cnt[k][1] <= 0;
            end else if (er0 || er1) begin
                pi = er1 ? 1 : 0;
                m_busy[k]    <= 1'b1;
                m_hs_cyc[k]  <= cyc;
                m_rsp_cyc[k] <= cyc + (we[k][pi] ? 2 : lat + 2);
                m_owner[k]   <= (pi == 1);
                m_last[k]    <= (pi == 1);
                m_we[k]      <= we[k][pi];
                e_mwe[k]     <= we[k][pi];
                e_maddr[k]   <= a[k][pi];
                e_mwdata[k]  <= wd[k][pi];
                m_rval[k]    <= ref_mem[k][a[k][pi]];
                if (we[k][pi]) ref_mem[k][a[k][pi]] <= wd[k][pi];
                if (m_cnt[k][pi] < 65535) m_cnt[k][pi] <= m_cnt[k][pi] + 1;
            end else if (m_busy[k] && (cyc == m_rsp_cyc[k])) begin
                m_busy[k] <= 1'b0;
            end
        end
        if (reset) started <= 1'b1;
        cyc <= cyc + 1;
    end

    task automatic new_request(input int k, input int p);
        int r;
        r        = $urandom_range(0, 3);
        v[k][p]  = 1'b1;
        we[k][p] = 1'($urandom_range(0, 1));
        a[k][p]  = (r == 0) ? 10'd0 : (r == 1) ? 10'd1023 : 10'($urandom_range(0, 15));
        wd[k][p] = $urandom;
    endtask

    initial begin
        bit both_phase;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                v[k][p]  = 1'b0;
                we[k][p] = 1'b0;
                a[k][p]  = {AW{1'b0}};
                wd[k][p] = {DW{1'b0}};
            end
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        // First access after reset: port 0 reads word 5 on both instances.
        for (int k = 0; k < 2; k++) begin
            v[k][0]  = 1'b1;
            we[k][0] = 1'b0;
            a[k][0]  = 10'd5;
        end
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            both_phase = (c >= 2000) && (c < 2600);
            reset = ($urandom_range(0, 149) == 0);
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < 2; p++) begin
                    if (v[k][p] && !acc[k][p]) begin
                        if (!both_phase && ($urandom_range(0, 15) == 0)) v[k][p] = 1'b0;
                    end else if (both_phase || ($urandom_range(0, 1) == 1)) begin
                        new_request(k, p);
                    end else begin
                        v[k][p] = 1'b0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            v[k][0] = 1'b0;
            v[k][1] = 1'b0;
        end
        repeat (8) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
